// File: rtl/scan_select_sequencer_if.sv
// ----------------------------------------------------------------------------
// scan_select_sequencer_if
// Bundles the control inputs and select outputs of scan_select_sequencer.
//   en        : scan enable (level)
//   dwell     : cycles-per-channel minus 1
//   ch_mask   : bit i=1 includes channel i in the scan
//   sel       : current channel index (decoder A)
//   sel_valid : sel is a live scan value
//   wrap      : one-cycle pulse when the scan returns to a lower-or-equal index
// Modports: master = controller side, slave = sequencer side.
// ----------------------------------------------------------------------------
interface scan_select_sequencer_if #(
  parameter int SEL_W   = 2,
  parameter int NUM_CH  = 4,
  parameter int DWELL_W = 8
);
  logic               en;
  logic [DWELL_W-1:0] dwell;
  logic [NUM_CH-1:0]  ch_mask;
  logic [SEL_W-1:0]   sel;
  logic               sel_valid;
  logic               wrap;

  modport master (
    output en, dwell, ch_mask,
    input  sel, sel_valid, wrap
  );

  modport slave (
    input  en, dwell, ch_mask,
    output sel, sel_valid, wrap
  );
endinterface

// File: rtl/scan_select_sequencer.sv
// ----------------------------------------------------------------------------
// scan_select_sequencer
// Steps a select code through the enabled channels in circular order, holding
// each channel for dwell+1 cycles, and pulses wrap whenever the scan returns
// to a lower-or-equal index. Intended to drive the A input of decoder_2x4.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : scan_select_sequencer_if.slave (en, dwell, ch_mask -> sel,
//         sel_valid, wrap); all outputs are registered.
// ----------------------------------------------------------------------------
module scan_select_sequencer #(
  parameter int SEL_W   = 2,
  parameter int NUM_CH  = 4,
  parameter int DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  scan_select_sequencer_if.slave bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  // Circular priority search: first set bit of mask strictly after cur,
  // wrapping around; returns cur itself when it is the only set bit.
  function automatic logic [SEL_W-1:0] f_next_ch(
    input logic [SEL_W-1:0]  cur,
    input logic [NUM_CH-1:0] mask
  );
    logic [SEL_W-1:0] idx;
    logic             found;
    f_next_ch = cur;
    found     = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = SEL_W'((int'(cur) + k) % NUM_CH);
      if (!found && mask[idx]) begin
        f_next_ch = idx;
        found     = 1'b1;
      end
    end
  endfunction

  state_t             r_state, w_state_nxt;
  logic [SEL_W-1:0]   r_sel, w_sel_nxt;
  logic               r_sel_valid, w_sel_valid_nxt;
  logic               r_wrap, w_wrap_nxt;
  logic [DWELL_W-1:0] r_cnt, w_cnt_nxt;
  logic [DWELL_W-1:0] r_dwell, w_dwell_nxt;
  logic [SEL_W-1:0]   w_first_ch;
  logic [SEL_W-1:0]   w_next_ch;
  logic               w_mask_any;

  // Searching after the top index yields the lowest set bit.
  assign w_first_ch = f_next_ch(SEL_W'(NUM_CH - 1), bus.ch_mask);
  assign w_next_ch  = f_next_ch(r_sel, bus.ch_mask);
  assign w_mask_any = |bus.ch_mask;

  // State and output registers; rst overrides everything, including mid-dwell.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sel       <= {SEL_W{1'b0}};
      r_sel_valid <= 1'b0;
      r_wrap      <= 1'b0;
      r_cnt       <= {DWELL_W{1'b0}};
      r_dwell     <= {DWELL_W{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_sel       <= w_sel_nxt;
      r_sel_valid <= w_sel_valid_nxt;
      r_wrap      <= w_wrap_nxt;
      r_cnt       <= w_cnt_nxt;
      r_dwell     <= w_dwell_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_sel_nxt       = r_sel;
    w_sel_valid_nxt = 1'b0;
    w_wrap_nxt      = 1'b0;
    w_cnt_nxt       = r_cnt;
    w_dwell_nxt     = r_dwell;
    case (r_state)
      ST_IDLE: begin
        if (bus.en && w_mask_any) begin
          w_state_nxt     = ST_SCAN;
          w_sel_nxt       = w_first_ch;
          w_sel_valid_nxt = 1'b1;
          w_cnt_nxt       = {DWELL_W{1'b0}};
          w_dwell_nxt     = bus.dwell;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (!bus.en || !w_mask_any) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt < r_dwell) begin
          // The running channel always finishes its latched dwell, even if
          // its mask bit has since been cleared.
          w_cnt_nxt       = r_cnt + {{(DWELL_W-1){1'b0}}, 1'b1};
          w_sel_valid_nxt = 1'b1;
        end else begin
          w_cnt_nxt       = {DWELL_W{1'b0}};
          w_dwell_nxt     = bus.dwell;
          w_sel_nxt       = w_next_ch;
          w_sel_valid_nxt = 1'b1;
          w_wrap_nxt      = (w_next_ch <= r_sel);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.sel       = r_sel;
  assign bus.sel_valid = r_sel_valid;
  assign bus.wrap      = r_wrap;

endmodule

// File: tb/tb_scan_select_sequencer.sv
// ----------------------------------------------------------------------------
// tb_scan_select_sequencer
// Directed scenarios with hand-computed expectations, followed by randomized
// traffic, all checked every cycle against a remaining-cycles reference model.
// ----------------------------------------------------------------------------
module tb_scan_select_sequencer;

  logic clk;
  logic rst;
  int   n_vec  = 0;
  int   n_miss = 0;
  logic chk_on = 1'b0;

  scan_select_sequencer_if #(.SEL_W(2), .NUM_CH(4), .DWELL_W(8)) bus();

  scan_select_sequencer #(.SEL_W(2), .NUM_CH(4), .DWELL_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [1:0] exp_sel   = 2'd0;
  logic       exp_valid = 1'b0;
  logic       exp_wrap  = 1'b0;
  logic       m_scan    = 1'b0;
  int         m_left    = 0;   // cycles still to hold the current channel

  function automatic int lowest(input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int after(input int cur, input logic [3:0] m);
    for (int k = 1; k <= 4; k++) if (m[(cur + k) % 4]) return (cur + k) % 4;
    return cur;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_scan <= 1'b0; exp_sel <= 2'd0; exp_valid <= 1'b0; exp_wrap <= 1'b0; m_left <= 0;
    end else if (!m_scan) begin
      exp_wrap <= 1'b0;
      if (bus.en && bus.ch_mask != 4'd0) begin
        m_scan    <= 1'b1;
        exp_sel   <= 2'(lowest(bus.ch_mask));
        exp_valid <= 1'b1;
        m_left    <= int'(bus.dwell);
      end else begin
        exp_valid <= 1'b0;
      end
    end else if (!bus.en || bus.ch_mask == 4'd0) begin
      m_scan <= 1'b0; exp_valid <= 1'b0; exp_wrap <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1; exp_wrap <= 1'b0;
    end else begin
      exp_sel  <= 2'(after(int'(exp_sel), bus.ch_mask));
      exp_wrap <= (after(int'(exp_sel), bus.ch_mask) <= int'(exp_sel));
      m_left   <= int'(bus.dwell);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      n_vec++;
      if (bus.sel !== exp_sel || bus.sel_valid !== exp_valid || bus.wrap !== exp_wrap) begin
        n_miss++;
        $display("FAIL model_cmp t=%0t: dut sel=%0d valid=%0b wrap=%0b, expected sel=%0d valid=%0b wrap=%0b",
                 $time, bus.sel, bus.sel_valid, bus.wrap, exp_sel, exp_valid, exp_wrap);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic r, input logic e, input logic [3:0] m, input logic [7:0] d);
    rst         = r;
    bus.en      = e;
    bus.ch_mask = m;
    bus.dwell   = d;
    @(posedge clk);
    #1;
  endtask

  // Hand-computed expectation: pins both the DUT and the model.
  task automatic lit(input string nm, input logic [1:0] s, input logic v, input logic w);
    n_vec++;
    if (bus.sel !== s || bus.sel_valid !== v || bus.wrap !== w ||
        exp_sel !== s || exp_valid !== v || exp_wrap !== w) begin
      n_miss++;
      $display("FAIL %s: dut sel=%0d valid=%0b wrap=%0b model sel=%0d valid=%0b wrap=%0b, required sel=%0d valid=%0b wrap=%0b",
               nm, bus.sel, bus.sel_valid, bus.wrap, exp_sel, exp_valid, exp_wrap, s, v, w);
    end
  endtask

  logic [1:0] full_seq [12] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};

  initial begin
    logic       r_i, e_i;
    logic [3:0] m_i;
    logic [7:0] d_i;

    rst = 1'b1; bus.en = 1'b0; bus.ch_mask = 4'd0; bus.dwell = 8'd0;

    // Reset held with en and a full mask.
    step(1'b1, 1'b1, 4'b1111, 8'd2);
    chk_on = 1'b1;
    lit("reset_c1", 2'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'b1111, 8'd2);
    lit("reset_c2", 2'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b1111, 8'd2);
    lit("release", 2'd0, 1'b1, 1'b0);

    // Full scan, dwell=2.
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 4'b1111, 8'd2);
      lit("full_scan", full_seq[i], 1'b1, (i == 11) ? 1'b1 : 1'b0);
    end

    // Sparse mask 1010, dwell=0.
    step(1'b0, 1'b0, 4'b1010, 8'd0);
    lit("idle_sparse", 2'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b1010, 8'd0);
    lit("sparse_0", 2'd1, 1'b1, 1'b0);
    for (int i = 1; i < 6; i++) begin
      step(1'b0, 1'b1, 4'b1010, 8'd0);
      lit("sparse", (i % 2 == 1) ? 2'd3 : 2'd1, 1'b1, (i % 2 == 0) ? 1'b1 : 1'b0);
    end

    // Single channel 0100, dwell=1.
    step(1'b0, 1'b0, 4'b0100, 8'd1);
    step(1'b0, 1'b1, 4'b0100, 8'd1);
    lit("single_0", 2'd2, 1'b1, 1'b0);
    for (int i = 1; i < 7; i++) begin
      step(1'b0, 1'b1, 4'b0100, 8'd1);
      lit("single", 2'd2, 1'b1, (i % 2 == 0) ? 1'b1 : 1'b0);
    end

    // Disable while sel=2.
    step(1'b0, 1'b0, 4'b1111, 8'd2);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 4'b1111, 8'd2);
    lit("pre_disable", 2'd2, 1'b1, 1'b0);
    step(1'b0, 1'b0, 4'b1111, 8'd2);
    lit("disable", 2'd2, 1'b0, 1'b0);

    // Mask 1111 -> 0011 while sel=2, dwell=1.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'b1111, 8'd1);
    lit("pre_maskchg", 2'd2, 1'b1, 1'b0);
    step(1'b0, 1'b1, 4'b0011, 8'd1);
    lit("maskchg_hold", 2'd2, 1'b1, 1'b0);
    step(1'b0, 1'b1, 4'b0011, 8'd1);
    lit("maskchg_wrap", 2'd0, 1'b1, 1'b1);

    // Reset mid-dwell at sel=3, counter=1.
    step(1'b0, 1'b0, 4'b1111, 8'd2);
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 4'b1111, 8'd2);
    lit("pre_rst", 2'd3, 1'b1, 1'b0);
    step(1'b1, 1'b1, 4'b1111, 8'd2);
    lit("rst_mid", 2'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b1100, 8'd2);
    lit("rst_restart", 2'd2, 1'b1, 1'b0);

    // Maximum dwell: channel held 256 cycles.
    step(1'b0, 1'b0, 4'b0011, 8'hFF);
    step(1'b0, 1'b1, 4'b0011, 8'hFF);
    lit("maxdwell_0", 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 255; i++) step(1'b0, 1'b1, 4'b0011, 8'hFF);
    lit("maxdwell_hold", 2'd0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 4'b0011, 8'hFF);
    lit("maxdwell_adv", 2'd1, 1'b1, 1'b0);

    // Randomized traffic.
    r_i = 1'b0; e_i = 1'b1; m_i = 4'b1111; d_i = 8'd1;
    for (int i = 0; i < 4000; i++) begin
      r_i = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) == 0) e_i = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 11) == 0) m_i = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) d_i = ($urandom_range(0, 40) == 0) ? 8'hFF : 8'($urandom_range(0, 4));
      step(r_i, e_i, m_i, d_i);
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
